srl_seq_player: RTL

Loader and cyclic sequencer that drives a shift-register table from both ends. It accepts a programmable-length frame of words on a valid/ready input stream and shifts them into an internal DEEP-entry SRL-style table, one word per accepted beat. It then plays the frame back in original write order on a valid/ready output stream, repeating it until stopped at a frame boundary. It sits between a configuration or DMA source and datapath consumers such as pattern generators, coefficient feeders and NCO tables.

---
 rtl/srl_seq_player.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/srl_seq_player.sv
// Loads a frame into a shift-register table, then plays it back cyclically in write order.
// The oldest word sits at the highest used address, so playback counts down from last_q to 0.
module srl_seq_player #(
  parameter int WIDTH     = 32,
  parameter int DEEP      = 32,
  parameter int DEEP_BITS = (DEEP < 32) ? 4 : (DEEP < 64) ? 5 : (DEEP < 128) ? 6 : 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEEP_BITS-1:0] cfg_last_i,
  input  logic                 load_start_i,
  input  logic [WIDTH-1:0]     s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic                 play_en_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 loaded_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_PLAY} state_t;

  state_t               state_q, state_d;
  logic [DEEP_BITS-1:0] last_q, last_d;
  logic [DEEP_BITS-1:0] cnt_q, cnt_d;
  logic [DEEP_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 loaded_q, loaded_d;
  logic                 busy_q, busy_d;
  logic                 out_ld;
  logic                 load_beat;

  logic [WIDTH-1:0] mem [DEEP];

  // Both streams: a beat transfers on a clock edge where valid and ready are both high;
  // a valid beat is held unchanged until it transfers.
  assign s_ready_o = (state_q == S_LOAD);
  assign load_beat = s_valid_i && (state_q == S_LOAD);

  // Table is deliberately not reset so it maps onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      mem[0] <= s_data_i;
      for (int j = 1; j < DEEP; j++) mem[j] <= mem[j-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    out_ld    = !m_valid_q || m_ready_i;
    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          last_d  = cfg_last_i;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        // A restart wins over a coincident beat: the word still shifts in but is not counted.
        if (load_start_i) begin
          last_d = cfg_last_i;
          cnt_d  = '0;
        end else if (s_valid_i) begin
          if (cnt_q == last_q) state_d = S_LOADED;
          else                 cnt_d   = cnt_q + 1'b1;
        end
      end
      S_LOADED: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          last_d  = cfg_last_i;
          cnt_d   = '0;
        end else if (play_en_i) begin
          state_d   = S_PLAY;
          rd_addr_d = last_q;
        end
      end
      S_PLAY: begin
        if (out_ld) begin
          // Stop only at a frame boundary, i.e. before fetching the first word again.
          if ((rd_addr_q == last_q) && !play_en_i) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = S_LOADED;
          end else begin
            m_data_d  = mem[rd_addr_q];
            m_last_d  = (rd_addr_q == '0);
            m_valid_d = 1'b1;
            rd_addr_d = (rd_addr_q == '0) ? last_q : rd_addr_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    loaded_d = (state_d == S_LOADED);
    busy_d   = (state_d == S_LOAD) || (state_d == S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign loaded_o  = loaded_q;
  assign busy_o    = busy_q;

endmodule
